uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

FIFO-buffered UART transmitter that is an io-bus peripheral. Software writes bytes into a transmit FIFO through a memory-mapped data register. A serializer drains the FIFO onto `uart_tx` as 8N1 frames, back-to-back. It complements the receive-side path (receiver plus RX FIFO) so that software can queue output without polling per character.

## Interface
- `BASE_ADDRESS`, default 0: byte address of the STATUS register. DATA is at `BASE_ADDRESS + 4`.
- `BAUD_DIVIDE`, default 2: clk cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 8: transmit FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `io_address` in 32: io-bus address.
- `io_read_en` in 1: read strobe.
- `io_write_data` in 32: write data; only [7:0] is used.
- `io_write_en` in 1: write strobe.
- `io_read_data` out 32: combinational read data.
- `uart_tx` out 1: serial output, registered; idles high.

## Operation
- **STATUS (BASE+0), read-only:**
  - bit0 = FIFO not full.
  - bit1 = FIFO empty.
  - bit2 = serializer busy (state ≠ IDLE).
  - bit3 = overflow, sticky.
  - bits[15:8] = FIFO count, zero-extended; width `$clog2(FIFO_DEPTH)+1`, range 0..FIFO_DEPTH.
  - All other bits are 0.
- **io_read_data:** reads of any other address return 0. The value is a function of `io_address` and current state only; `io_read_en` does not gate it.
- **DATA (BASE+4), write:**
  - `io_write_en` with FIFO not full enqueues `io_write_data[7:0]`.
  - A write while full is dropped and sets overflow.
  - "Full" is evaluated on the pre-edge count, so a same-cycle dequeue does not make room.
- **Overflow clear:** overflow clears on the edge of a cycle where `io_read_en` is set and the address is STATUS. If a set and a clear happen in the same cycle, the set wins.
- **FIFO:** enqueue and dequeue can occur in the same cycle, and the count is unchanged in that case. There is no bypass: a byte written into an empty FIFO is dequeued no earlier than the next cycle. Pointers wrap modulo FIFO_DEPTH.
- **Serializer states:** IDLE, START, DATA, STOP. It uses a baud counter (0..BAUD_DIVIDE-1), a 3-bit bit index, and an 8-bit shift register.
  - **IDLE:** `uart_tx`=1. If the FIFO is non-empty: dequeue, load the shifter, go to START.
  - **START:** `uart_tx`=0 for BAUD_DIVIDE cycles, then go to DATA with bit index 0.
  - **DATA:** `uart_tx`=shifter[0], LSB first. Each bit lasts BAUD_DIVIDE cycles, then shift right. After bit 7, go to STOP.
  - **STOP:** `uart_tx`=1 for BAUD_DIVIDE cycles. On the final stop cycle: if the FIFO is non-empty, dequeue and go directly to START; otherwise go to IDLE.
- **Reset values:** `uart_tx`=1, state IDLE, FIFO empty (count 0), overflow 0, counters 0. In `io_read_data` terms, STATUS reads 0x00000003.
- **Reset mid-frame:** the frame is abandoned, `uart_tx`=1 from the cycle after the reset edge, and queued bytes are discarded.

## Timing
- **Write to start bit:** DATA write in cycle N, with FIFO empty and state IDLE:
  - Count reads 1 in N+1; the dequeue also happens in N+1.
  - `uart_tx` falls at N+2.
  - The start bit covers N+2 .. N+1+BAUD_DIVIDE.
  - Data bit i begins at N+2+(i+1)·BAUD_DIVIDE.
  - The stop bit begins at N+2+9·BAUD_DIVIDE.
- **Frame length:** exactly 10·BAUD_DIVIDE cycles.
- **Back-to-back frames:** the next start bit begins in the cycle immediately after the last stop cycle, with no idle gap.
- **Busy flag:** busy=1 from N+2 through the end of the last frame; it reads 0 in the first IDLE cycle.

## Test plan
- **Single byte:** reset, BAUD_DIVIDE=4, write 0x55 to DATA at cycle N.
  - `uart_tx` samples at N+2+4k for k=0..9 must be 0,1,0,1,0,1,0,1,0,1.
  - `uart_tx` is high from N+42 onward.
  - STATUS reads 0x00000003 after the frame completes.
- **Back-to-back:** write 0x00, 0xFF, 0xA5 in consecutive cycles.
  - Three contiguous 40-cycle frames with no idle gaps between them.
  - STATUS count reads 1, 1, 2 in the three cycles after the writes, respectively.
- **Overflow:** FIFO_DEPTH=8, write 0x00..0x09 in 10 consecutive cycles.
  - Byte 0x09 is dropped; 9 frames 0x00..0x08 are emitted.
  - STATUS bit3=1, and bit0=0 after the final write.
  - A STATUS read clears bit3 on the next cycle.
- **Read-clear priority:** a STATUS read in the same cycle as a write-while-full leaves overflow=1.
- **Reset mid-frame:** assert reset during data bit 3 of the second of 3 queued bytes.
  - `uart_tx`=1 the following cycle; STATUS=0x00000003.
  - No further frames are emitted.
- **Address decode:** a read of BASE+8 returns 0; a write to BASE+0 does not change the FIFO count.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter on the io-bus
module uart_tx_buffered #(
    parameter logic [31:0] BASE_ADDRESS = 32'd0,
    parameter int          BAUD_DIVIDE  = 2,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_address,
    input  logic        io_read_en,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic [31:0] io_read_data,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIVIDE);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIVIDE - 1);
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDRESS;
    localparam logic [31:0]   DATA_ADDR   = BASE_ADDRESS + 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic fifo_full;
    logic fifo_empty;
    logic write_hit;
    logic status_read;
    logic enq;
    logic deq;
    logic unused_write_bits;

    // Only the low byte of a DATA write carries payload.
    assign unused_write_bits = ^io_write_data[31:8];

    // Full/empty come from the pre-edge count so a same-cycle dequeue never makes room.
    assign fifo_full   = (count_q == FULL_COUNT);
    assign fifo_empty  = (count_q == '0);
    assign write_hit   = io_write_en && (io_address == DATA_ADDR);
    assign status_read = io_read_en && (io_address == STATUS_ADDR);
    assign enq         = write_hit && !fifo_full;
    assign uart_tx     = tx_q;

    // Read mux: STATUS is the only readable register; read strobe does not gate it.
    always_comb begin
        io_read_data = '0;
        if (io_address == STATUS_ADDR) begin
            io_read_data = {16'd0, 8'(count_q), 4'd0, ovf_q, (state_q != S_IDLE),
                            fifo_empty, !fifo_full};
        end
    end

    // FIFO pointer/count bookkeeping and sticky overflow (set beats read-clear).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CW'(1);
        end
        if (write_hit && fifo_full) begin
            ovf_d = 1'b1;
        end else if (status_read) begin
            ovf_d = 1'b0;
        end
    end

    // Serializer next state; the stop bit's last cycle chains straight into the next start bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        deq     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    deq     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        deq     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so the output is registered without extra lag.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
    end

    // FIFO storage; contents need no reset because count/pointers gate their use.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= io_write_data[7:0];
        end
    end

    // State registers with synchronous reset; reset abandons any frame and drops queued bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;
    localparam logic [31:0] BASE = 32'h40;
    localparam int B = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_address = 32'd0;
    logic        io_read_en = 1'b0;
    logic [31:0] io_write_data = 32'd0;
    logic        io_write_en = 1'b0;
    logic [31:0] io_read_data;
    logic        uart_tx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .BASE_ADDRESS(BASE),
        .BAUD_DIVIDE (B),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_address   (io_address),
        .io_read_en   (io_read_en),
        .io_write_data(io_write_data),
        .io_write_en  (io_write_en),
        .io_read_data (io_read_data),
        .uart_tx      (uart_tx)
    );

    // Reference: queue of pending bytes plus position within the current 10*B-cycle frame.
    byte unsigned mq[$];
    logic [7:0]   m_cur = 8'd0;
    int           m_pos = -1;
    logic         m_ovf = 1'b0;

    function automatic logic m_tx();
        int slot;
        if (m_pos < 0) return 1'b1;
        slot = m_pos / B;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    function automatic logic [31:0] m_rd(logic [31:0] a);
        if (a != BASE) return 32'd0;
        return {16'd0, 8'(mq.size()), 4'd0, m_ovf, (m_pos >= 0), (mq.size() == 0), (mq.size() != D)};
    endfunction

    task automatic model_step();
        logic was_full;
        logic was_empty;
        logic wr;
        if (reset) begin
            mq.delete();
            m_pos = -1;
            m_ovf = 1'b0;
            return;
        end
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        wr        = io_write_en && (io_address == BASE + 32'd4);
        if (!was_empty && (m_pos < 0 || m_pos == 10*B-1)) begin
            m_cur = mq.pop_front();
            m_pos = 0;
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == 10*B-1) ? -1 : m_pos + 1;
        end
        if (wr && !was_full) mq.push_back(io_write_data[7:0]);
        if (wr && was_full) m_ovf = 1'b1;
        else if (io_read_en && io_address == BASE) m_ovf = 1'b0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_tx", {31'd0, uart_tx}, {31'd0, m_tx()});
        chk("model_rd", io_read_data, m_rd(io_address));
    endtask

    task automatic drive(logic r, logic [31:0] a, logic rd, logic wr, logic [7:0] d);
        reset         = r;
        io_address    = a;
        io_read_en    = rd;
        io_write_en   = wr;
        io_write_data = {24'($urandom), d};
    endtask

    task automatic peek_status(output logic [31:0] v);
        logic [31:0] saved;
        saved      = io_address;
        io_address = BASE;
        #1;
        v          = io_read_data;
        io_address = saved;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wd;
        logic        exp_tx;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] st;
        logic [9:0]  pat;
        int          sel;

        tbl[0]  = '{1'b1, BASE,          1'b0, 1'b0, 8'h00, 1'b1, 32'h3};
        tbl[1]  = '{1'b0, BASE + 32'd8,  1'b1, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, BASE,          1'b0, 1'b1, 8'h12, 1'b1, 32'h3};
        tbl[3]  = '{1'b0, BASE + 32'd4,  1'b0, 1'b1, 8'h55, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b0, 32'h7};
        tbl[5]  = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b0, 32'h7};
        tbl[6]  = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b0, 32'h7};
        tbl[7]  = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b0, 32'h7};
        tbl[8]  = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b1, 32'h7};
        tbl[9]  = '{1'b0, BASE + 32'd4,  1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[10] = '{1'b0, BASE,          1'b1, 1'b0, 8'h00, 1'b1, 32'h7};
        tbl[11] = '{1'b0, BASE,          1'b0, 1'b0, 8'h00, 1'b1, 32'h7};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wd);
            tick();
            chk($sformatf("tbl%0d_tx", i), {31'd0, uart_tx}, {31'd0, tbl[i].exp_tx});
            chk($sformatf("tbl%0d_rd", i), io_read_data, tbl[i].exp_rd);
        end
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) tick();
        chk("drain1_status", io_read_data, 32'h3);

        // Single byte with explicit bit sampling at N+2+4k.
        pat = 10'b1010101010;
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'h55);
        tick();
        peek_status(st);
        chk("single_count1", st, 32'h101);
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("single_bit%0d", k), {31'd0, uart_tx}, {31'd0, pat[k]});
            for (int j = 0; j < 4; j++) tick();
        end
        chk("single_idle_tx", {31'd0, uart_tx}, 32'd1);
        chk("single_status", io_read_data, 32'h3);

        // Back-to-back: three contiguous frames, count 1,1,2.
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'h00);
        tick();
        peek_status(st);
        chk("b2b_count_a", {24'd0, st[15:8]}, 32'd1);
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'hFF);
        tick();
        peek_status(st);
        chk("b2b_count_b", {24'd0, st[15:8]}, 32'd1);
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'hA5);
        tick();
        peek_status(st);
        chk("b2b_count_c", {24'd0, st[15:8]}, 32'd2);
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 39; i++) tick();
        chk("b2b_frame2_start", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("b2b_frame3_start", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("b2b_idle_tx", {31'd0, uart_tx}, 32'd1);
        chk("b2b_status", io_read_data, 32'h3);

        // Overflow: ten writes into an 8-deep FIFO.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'(i));
            tick();
        end
        peek_status(st);
        chk("ovf_status", st, 32'h80C);
        drive(1'b0, BASE + 32'd4, 1'b1, 1'b1, 8'hEE);
        tick();
        peek_status(st);
        chk("ovf_hold_on_full_write", st, 32'h80C);
        drive(1'b0, BASE, 1'b1, 1'b0, 8'h00);
        tick();
        chk("ovf_cleared", io_read_data, 32'h804);
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 380; i++) tick();
        chk("ovf_drained", io_read_data, 32'h3);

        // Reset during data bit 3 of the second of three frames.
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'h3C);
        tick();
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'hC3);
        tick();
        drive(1'b0, BASE + 32'd4, 1'b0, 1'b1, 8'h5A);
        tick();
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 56; i++) tick();
        drive(1'b1, BASE, 1'b0, 1'b0, 8'h00);
        tick();
        chk("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_mid_status", io_read_data, 32'h3);
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1) chk("rst_no_frames", {31'd0, uart_tx}, 32'd1);
        end
        chk("rst_quiet_status", io_read_data, 32'h3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 7));
            drive(($urandom_range(0, 399) == 0),
                  (sel < 4) ? BASE + 32'd4 : (sel < 6) ? BASE : (sel == 6) ? BASE + 32'd8 : $urandom,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  8'($urandom));
            tick();
        end
        drive(1'b0, BASE, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) tick();
        chk("final_tx", {31'd0, uart_tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
